// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants and types for the ternary re-quantiser
// Purpose: ternary output codes, o_err bit positions and the threshold pair layout.
// Ports: none (package).
package bnn_pkg;

    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;

    localparam int ERR_PIX = 0;
    localparam int ERR_CH  = 1;
    localparam int ERR_ROW = 2;

    localparam int TH_W = 26;

    // hi occupies the upper half so the pair matches the {th_hi, th_lo} write word
    typedef struct packed {
        logic signed [TH_W-1:0] hi;
        logic signed [TH_W-1:0] lo;
    } th_pair_t;

endpackage

// File: rtl/th_ram.sv
// rtl/th_ram.sv - simple dual-port threshold RAM with registered read
// Purpose: one write port, one synchronous read port, 1-cycle read latency.
//          A read of the address being written in the same cycle returns the old word.
//          Contents are not reset.
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write word
//   i_rd_addr  read address, sampled every cycle
//   o_rd_data  read word, valid one cycle after i_rd_addr
module th_ram #(
    parameter int DATA_W = 52,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Both accesses in one block: the read samples the pre-write word.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bact_quant_g2.sv
// rtl/bact_quant_g2.sv - ternary re-quantiser with stream geometry checks
// Purpose: thresholds each signed accumulation against a per-channel {hi, lo} pair
//          and emits a 2-bit ternary code with the sideband, 2 cycles later.
//          Sticky error flags report pixel-count, channel-overflow and row-count faults.
// Ports:
//   i_sclk, i_rst_n                       clock, async active-low reset
//   i_vsync, i_hsync, i_reuse, i_valid    frame / row / channel-row / data strobes
//   i_tdata                               signed accumulation
//   i_th_vld, i_th_addr, i_th_data        threshold write port ({th_hi, th_lo})
//   o_vsync, o_hsync, o_reuse, o_valid    sideband, delayed 2 cycles
//   o_tdata                               ternary code (00: 0, 01: +1, 11: -1)
//   o_err                                 sticky errors {row, channel, pixel}
module bact_quant_g2
    import bnn_pkg::*;
#(
    parameter int WIDTH_I = 26,
    parameter int WIDTH_D = 2,
    parameter int CHANNEL = 128,
    parameter int SIZE    = 28,
    parameter int ADDR_W  = 7
) (
    input  logic                 i_sclk,
    input  logic                 i_rst_n,
    input  logic                 i_vsync,
    input  logic                 i_hsync,
    input  logic                 i_reuse,
    input  logic                 i_valid,
    input  logic [WIDTH_I-1:0]   i_tdata,
    input  logic                 i_th_vld,
    input  logic [ADDR_W-1:0]    i_th_addr,
    input  logic [2*WIDTH_I-1:0] i_th_data,
    output logic                 o_vsync,
    output logic                 o_hsync,
    output logic                 o_reuse,
    output logic                 o_valid,
    output logic [WIDTH_D-1:0]   o_tdata,
    output logic [2:0]           o_err
);

    localparam int CNT_W = $clog2(SIZE + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(SIZE + 1);
    localparam logic [ADDR_W:0]   NXT_END  = (ADDR_W + 1)'(CHANNEL);
    localparam logic [ADDR_W-1:0] CH_LAST  = ADDR_W'(CHANNEL - 1);

    logic [ADDR_W-1:0]          r_cur_ch;
    logic [ADDR_W:0]            r_nxt_ch;
    logic [CNT_W-1:0]           r_pix_cnt;
    logic [CNT_W-1:0]           r_row_cnt;
    logic                       r_row_open;
    logic                       r_frame_open;
    logic                       r_armed;
    logic [2:0]                 r_err;

    logic                       r_s1_vsync, r_s1_hsync, r_s1_reuse, r_s1_valid;
    logic signed [WIDTH_I-1:0]  r_s1_x;
    logic                       r_o_vsync, r_o_hsync, r_o_reuse, r_o_valid;
    logic [WIDTH_D-1:0]         r_o_tdata;

    logic                       w_line;
    logic [ADDR_W:0]            w_nxt_base;
    logic                       w_ch_ovf;
    logic                       w_pix_bad;
    logic                       w_row_bad;
    logic [2*WIDTH_I-1:0]       w_th_rd;
    logic signed [WIDTH_I-1:0]  w_th_hi;
    logic signed [WIDTH_I-1:0]  w_th_lo;
    logic [WIDTH_D-1:0]         w_q;

    th_ram #(
        .DATA_W (2 * WIDTH_I),
        .DEPTH  (CHANNEL),
        .ADDR_W (ADDR_W)
    ) u_th_ram (
        .i_clk     (i_sclk),
        .i_wr_en   (i_th_vld),
        .i_wr_addr (i_th_addr),
        .i_wr_data (i_th_data),
        .i_rd_addr (r_cur_ch),
        .o_rd_data (w_th_rd)
    );

    // hsync/vsync clear nxt_ch before a coincident reuse consumes it
    assign w_line     = i_hsync | i_vsync;
    assign w_nxt_base = w_line ? '0 : r_nxt_ch;
    assign w_ch_ovf   = i_reuse & (w_nxt_base == NXT_END);
    assign w_pix_bad  = (i_reuse | w_line) & r_row_open & (r_pix_cnt != CNT_FULL);
    assign w_row_bad  = i_vsync & r_frame_open & (r_row_cnt != CNT_FULL);

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur_ch <= '0;
            r_nxt_ch <= '0;
        end else if (i_reuse) begin
            if (w_ch_ovf) begin
                r_cur_ch <= CH_LAST;
                r_nxt_ch <= NXT_END;
            end else begin
                r_cur_ch <= w_nxt_base[ADDR_W-1:0];
                r_nxt_ch <= w_nxt_base + (ADDR_W + 1)'(1);
            end
        end else if (w_line) begin
            r_nxt_ch <= '0;
        end
    end

    // Geometry tracking. r_armed stays low until the first vsync after reset so
    // that a stream joined mid-frame is quantised but never flagged.
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_cnt    <= '0;
            r_row_cnt    <= '0;
            r_row_open   <= 1'b0;
            r_frame_open <= 1'b0;
            r_armed      <= 1'b0;
            r_err        <= '0;
        end else begin
            if (i_reuse) begin
                r_pix_cnt  <= '0;
                r_row_open <= 1'b1;
            end else begin
                if (w_line) begin
                    r_row_open <= 1'b0;
                end
                if (i_valid && (r_pix_cnt != CNT_SAT)) begin
                    r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                end
            end

            if (i_vsync) begin
                r_row_cnt    <= i_hsync ? CNT_W'(1) : '0;
                r_frame_open <= i_hsync;
                r_armed      <= 1'b1;
            end else if (i_hsync) begin
                if (r_row_cnt != CNT_SAT) begin
                    r_row_cnt <= r_row_cnt + CNT_W'(1);
                end
                if (r_armed) begin
                    r_frame_open <= 1'b1;
                end
            end

            if (r_armed) begin
                if (w_pix_bad) r_err[ERR_PIX] <= 1'b1;
                if (w_ch_ovf)  r_err[ERR_CH]  <= 1'b1;
                if (w_row_bad) r_err[ERR_ROW] <= 1'b1;
            end
        end
    end

    // Stage 1: sideband and x registered alongside the RAM read of cur_ch
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_vsync <= 1'b0;
            r_s1_hsync <= 1'b0;
            r_s1_reuse <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_x     <= '0;
        end else begin
            r_s1_vsync <= i_vsync;
            r_s1_hsync <= i_hsync;
            r_s1_reuse <= i_reuse;
            r_s1_valid <= i_valid;
            r_s1_x     <= i_tdata;
        end
    end

    assign w_th_hi = w_th_rd[2*WIDTH_I-1:WIDTH_I];
    assign w_th_lo = w_th_rd[WIDTH_I-1:0];

    // The hi test wins when lo > hi
    always_comb begin
        w_q = TERN_ZERO;
        if (r_s1_valid) begin
            if (r_s1_x >= w_th_hi) begin
                w_q = TERN_POS;
            end else if (r_s1_x < w_th_lo) begin
                w_q = TERN_NEG;
            end
        end
    end

    // Stage 2: registered outputs
    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_o_vsync <= 1'b0;
            r_o_hsync <= 1'b0;
            r_o_reuse <= 1'b0;
            r_o_valid <= 1'b0;
            r_o_tdata <= '0;
        end else begin
            r_o_vsync <= r_s1_vsync;
            r_o_hsync <= r_s1_hsync;
            r_o_reuse <= r_s1_reuse;
            r_o_valid <= r_s1_valid;
            r_o_tdata <= w_q;
        end
    end

    assign o_vsync = r_o_vsync;
    assign o_hsync = r_o_hsync;
    assign o_reuse = r_o_reuse;
    assign o_valid = r_o_valid;
    assign o_tdata = r_o_tdata;
    assign o_err   = r_err;

endmodule
